// File: rtl/seg_pkg.sv
// Shared constants for seven-segment display drivers: glyph encodings
// ({g,f,e,d,c,b,a}, active low) and all-off levels for anodes and segments.
package seg_pkg;

   localparam logic [3:0] NIBBLE_BLANK = 4'hF;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = SEG_OFF;

   typedef enum logic {
      PH_DEAD = 1'b0,
      PH_LIT  = 1'b1
   } slot_phase_e;

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational nibble to active-low seven-segment map. Nibble F is the
// blank glyph so upstream muxes can switch a digit off by data alone.
module seg_glyph_decoder
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      unique case (nibble)
         4'h0: seg = GLYPH_0;
         4'h1: seg = GLYPH_1;
         4'h2: seg = GLYPH_2;
         4'h3: seg = GLYPH_3;
         4'h4: seg = GLYPH_4;
         4'h5: seg = GLYPH_5;
         4'h6: seg = GLYPH_6;
         4'h7: seg = GLYPH_7;
         4'h8: seg = GLYPH_8;
         4'h9: seg = GLYPH_9;
         4'hA: seg = GLYPH_A;
         4'hB: seg = GLYPH_B;
         4'hC: seg = GLYPH_C;
         4'hD: seg = GLYPH_D;
         4'hE: seg = GLYPH_E;
         4'hF: seg = GLYPH_F;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for an 8-digit common-anode display. Data is latched
// once per frame; each digit slot opens with a dead-time gap to stop ghosting.
module seven_seg_scanner
   import seg_pkg::*;
#(
   parameter int DIGIT_PERIOD = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] display_data,
   input  logic [7:0]  dp_en,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int              CNT_W     = $clog2(DIGIT_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [31:0]      frame_data_q, frame_data_d;
   logic [7:0]       frame_dp_q, frame_dp_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             frame_done_q, frame_done_d;

   logic             slot_end;
   logic             frame_end;
   slot_phase_e      phase;
   logic [3:0]       cur_nibble;
   logic [6:0]       cur_glyph;

   assign slot_end   = (cnt_q == CNT_LAST);
   assign frame_end  = slot_end && (idx_q == 3'd7);
   assign phase      = (cnt_q < BLANK_END) ? PH_DEAD : PH_LIT;
   assign cur_nibble = frame_data_q[{idx_q, 2'b00} +: 4];

   seg_glyph_decoder u_glyph (
      .nibble (cur_nibble),
      .seg    (cur_glyph)
   );

   always_comb begin
      cnt_d        = cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      frame_data_d = frame_data_q;
      frame_dp_d   = frame_dp_q;
      frame_done_d = 1'b0;

      if (slot_end) begin
         cnt_d = '0;
         idx_d = idx_q + 3'd1;
      end

      // Capture only at the frame boundary so a frame never shows mixed data.
      if (frame_end) begin
         frame_data_d = display_data;
         frame_dp_d   = dp_en;
         frame_done_d = 1'b1;
      end
   end

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;

      if (phase == PH_LIT) begin
         an_d[idx_q] = 1'b0;
         seg_d       = cur_glyph;
         dp_d        = ~frame_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         frame_data_q <= 32'hFFFF_FFFF;
         frame_dp_q   <= 8'h00;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         frame_data_q <= frame_data_d;
         frame_dp_q   <= frame_dp_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule
